// File: rtl/seg_scan_driver.sv
// Multiplexed 6-digit 7-segment scanner: per-frame snapshot, dead time, overflow dashes.
// Optional leading-zero blanking when LZ_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SCAN_HZ     = 1_000,
    parameter int DEAD_CYC    = 2,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter int DP_DIGIT    = 6
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [23:0] data_in,
    input  logic        ovf_in,
    output logic [7:0]  seg,
    output logic [5:0]  dig_sel,
    output logic        frame
);
    localparam int DIV = CLK_HZ / (SCAN_HZ * 6);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] DEADV = CW'(DEAD_CYC);
    localparam logic [7:0] SEG_OFF  = SEG_ACT_LOW ? 8'hFF : 8'h00;

    logic [CW-1:0] tick_cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          snap_ovf;
    logic          slot_end, frame_end;
    logic [3:0]    nib;
    logic [7:0]    glyph;

    assign slot_end  = (tick_cnt == LAST);
    assign frame_end = slot_end && (idx == 3'd5);

    always_comb begin
        nib = 4'h0;
        for (int k = 0; k < 6; k++)
            if (idx == 3'(k)) nib = snap[4*k +: 4];
    end

`ifdef LZ_BLANK_EN
    // lead[k]: snapshot nibbles k..5 are all zero
    logic [5:0] lead;
    always_comb begin
        lead = '0;
        lead[5] = (snap[23:20] == 4'h0);
        for (int k = 4; k >= 0; k--)
            lead[k] = lead[k+1] && (snap[4*k +: 4] == 4'h0);
    end
`endif

    always_comb begin
        glyph = 8'h00;
        if (snap_ovf) begin
            glyph = 8'h40;
        end else begin
            if (nib > 4'd9)
                glyph = 8'h79;
`ifdef LZ_BLANK_EN
            else if (idx != 3'd0 && lead[idx])
                glyph = 8'h00;
`endif
            else begin
                case (nib)
                    4'd0: glyph = 8'h3F;
                    4'd1: glyph = 8'h06;
                    4'd2: glyph = 8'h5B;
                    4'd3: glyph = 8'h4F;
                    4'd4: glyph = 8'h66;
                    4'd5: glyph = 8'h6D;
                    4'd6: glyph = 8'h7D;
                    4'd7: glyph = 8'h07;
                    4'd8: glyph = 8'h7F;
                    4'd9: glyph = 8'h6F;
                    default: glyph = 8'h00;
                endcase
            end
            if (idx == 3'(DP_DIGIT)) glyph[7] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            tick_cnt <= '0;
            idx      <= 3'd0;
            snap     <= 24'h0;
            snap_ovf <= 1'b0;
            seg      <= SEG_OFF;
            dig_sel  <= 6'b0;
            frame    <= 1'b0;
        end else begin
            tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;
            if (slot_end) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (frame_end) begin
                snap     <= data_in;
                snap_ovf <= ovf_in;
            end
            frame <= frame_end;
            // outputs lag (tick_cnt, idx) by one cycle
            if (tick_cnt < DEADV) begin
                dig_sel <= 6'b0;
                seg     <= SEG_OFF;
            end else begin
                dig_sel <= 6'b1 << idx;
                seg     <= glyph ^ {8{SEG_ACT_LOW}};
            end
        end
    end
endmodule
